// File: rtl/fifo_write_ctrl_if.sv
// Write-side FIFO controller bus: upstream write request, read-side
// accepted-read pulse, and the RAM write strobe / address / status back out.
// The slave modport is used by fifo_write_ctrl; the master modport is used by
// whoever drives the requests and observes the status.
interface fifo_write_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              i_wen;
  logic              i_ren_ctrl;
  logic              i_err_clr;
  logic              o_wen_ctrl;
  logic [ADDR_W-1:0] o_waddr;
  logic              o_full;
  logic              o_almost_full;
  logic              o_empty;
  logic [ADDR_W:0]   o_count;
  logic              o_ovf;
  logic              o_udf;

  modport master (
    output i_wen, i_ren_ctrl, i_err_clr,
    input  o_wen_ctrl, o_waddr, o_full, o_almost_full, o_empty,
           o_count, o_ovf, o_udf
  );

  modport slave (
    input  i_wen, i_ren_ctrl, i_err_clr,
    output o_wen_ctrl, o_waddr, o_full, o_almost_full, o_empty,
           o_count, o_ovf, o_udf
  );
endinterface

// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write-side controller for the block FIFO.
// Gates upstream writes against occupancy, issues a registered RAM write
// strobe and address, tracks the occupancy count and decodes the status
// flags from it. Optional sticky overflow/underflow flags are enabled by
// defining FIFO_WR_ERR_EN; otherwise o_ovf/o_udf are tied low.
module fifo_write_ctrl #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rest,
  fifo_write_ctrl_if.slave     bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AF_C     = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wptr;
  logic [CNT_W-1:0]  count;
  logic              wen_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              full;
  logic              empty;
  logic              accept;
  logic              rd_ok;

  // Status decoded from the registered count only, so there is no
  // combinational input-to-output path.
  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  assign accept = bus.i_wen & ~full;
  assign rd_ok  = bus.i_ren_ctrl & ~empty;

  // Write pointer, registered RAM strobe/address and occupancy count.
  always_ff @(posedge i_clk) begin
    if (!i_rest) begin
      wptr    <= '0;
      count   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
    end else begin
      wen_q   <= accept;
      waddr_q <= wptr;
      if (accept) begin
        // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
        wptr <= (wptr == LAST_PTR) ? '0 : wptr + PTR_ONE;
      end
      if (accept && !rd_ok) begin
        count <= count + CNT_ONE;
      end else if (!accept && rd_ok) begin
        count <= count - CNT_ONE;
      end
    end
  end

  assign bus.o_wen_ctrl    = wen_q;
  assign bus.o_waddr       = waddr_q;
  assign bus.o_full        = full;
  assign bus.o_almost_full = (count >= AF_C);
  assign bus.o_empty       = empty;
  assign bus.o_count       = count;

`ifdef FIFO_WR_ERR_EN
  logic ovf_q;
  logic udf_q;

  // Sticky error flags; a set in the same cycle as a clear takes priority.
  always_ff @(posedge i_clk) begin
    if (!i_rest) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.i_wen && full) begin
        ovf_q <= 1'b1;
      end else if (bus.i_err_clr) begin
        ovf_q <= 1'b0;
      end
      if (bus.i_ren_ctrl && empty) begin
        udf_q <= 1'b1;
      end else if (bus.i_err_clr) begin
        udf_q <= 1'b0;
      end
    end
  end

  assign bus.o_ovf = ovf_q;
  assign bus.o_udf = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.i_err_clr;
  assign bus.o_ovf = 1'b0;
  assign bus.o_udf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Testbench for fifo_write_ctrl (DEPTH=5, non-power-of-two, ADDR_W=3).
// Directed scenarios followed by randomized traffic against an occupancy /
// accepted-write-count reference model.
module tb_fifo_write_ctrl;
  localparam int DEPTH     = 5;
  localparam int ADDR_W    = 3;
  localparam int AF_MARGIN = 2;
  localparam int CW        = ADDR_W + 1;
`ifdef FIFO_WR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic i_clk  = 1'b0;
  logic i_rest = 1'b0;

  fifo_write_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  fifo_write_ctrl #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .AF_MARGIN(AF_MARGIN)
  ) dut (
    .i_clk(i_clk),
    .i_rest(i_rest),
    .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy and total writes accepted since reset.
  int          m_cnt   = 0;
  int unsigned m_acc   = 0;
  bit          m_wen   = 1'b0;
  int          m_waddr = 0;
  bit          m_ovf   = 1'b0;
  bit          m_udf   = 1'b0;

  task automatic step(input bit rst_n, input bit wen, input bit ren, input bit clr);
    int acc;
    int rd;
    i_rest         = rst_n;
    bus.i_wen      = wen;
    bus.i_ren_ctrl = ren;
    bus.i_err_clr  = clr;
    @(posedge i_clk);
    if (!rst_n) begin
      m_cnt = 0; m_acc = 0; m_wen = 1'b0; m_waddr = 0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      acc = (wen && m_cnt < DEPTH) ? 1 : 0;
      rd  = (ren && m_cnt > 0) ? 1 : 0;
      if (ERR_EN) begin
        if (wen && m_cnt == DEPTH) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (ren && m_cnt == 0) m_udf = 1'b1;
        else if (clr) m_udf = 1'b0;
      end
      m_wen   = (acc == 1);
      m_waddr = int'(m_acc % DEPTH);
      m_acc   = m_acc + acc;
      m_cnt   = m_cnt + acc - rd;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.o_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.o_count); end
    checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.o_empty); end
    checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.o_full); end
    checks++; if (bus.o_almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", bus.o_almost_full); end
    checks++; if (bus.o_wen_ctrl !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", bus.o_wen_ctrl); end
    checks++; if (bus.o_waddr !== '0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", bus.o_waddr); end
    checks++; if (bus.o_ovf !== 1'b0 || bus.o_udf !== 1'b0) begin errors++; $display("FAIL reset_err got ovf=%b udf=%b exp 0 0", bus.o_ovf, bus.o_udf); end
  endtask

  task automatic test_fill();
    int c;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      c = (k < DEPTH) ? k : DEPTH;
      checks++; if (bus.o_wen_ctrl !== (k <= DEPTH)) begin errors++; $display("FAIL fill_wen k=%0d got %b exp %b", k, bus.o_wen_ctrl, k <= DEPTH); end
      checks++; if (bus.o_waddr !== ADDR_W'((k <= DEPTH) ? k - 1 : 0)) begin errors++; $display("FAIL fill_waddr k=%0d got %0d", k, bus.o_waddr); end
      checks++; if (bus.o_count !== CW'(c)) begin errors++; $display("FAIL fill_count k=%0d got %0d exp %0d", k, bus.o_count, c); end
      checks++; if (bus.o_full !== (c == DEPTH)) begin errors++; $display("FAIL fill_full k=%0d got %b exp %b", k, bus.o_full, c == DEPTH); end
      checks++; if (bus.o_almost_full !== (c >= DEPTH - AF_MARGIN)) begin errors++; $display("FAIL fill_af k=%0d got %b exp %b", k, bus.o_almost_full, c >= DEPTH - AF_MARGIN); end
      checks++; if (bus.o_ovf !== (ERR_EN && k > DEPTH)) begin errors++; $display("FAIL fill_ovf k=%0d got %b exp %b", k, bus.o_ovf, ERR_EN && k > DEPTH); end
    end
  endtask

  task automatic test_wrap();
    int exp_addr [8] = '{0, 1, 2, 3, 4, 0, 1, 2};
    int n = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if (bus.o_wen_ctrl !== 1'b1 || bus.o_waddr !== ADDR_W'(exp_addr[n])) begin errors++; $display("FAIL wrap_addr n=%0d got wen=%b addr=%0d exp 1 %0d", n, bus.o_wen_ctrl, bus.o_waddr, exp_addr[n]); end
      n++;
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL wrap_drained got %b exp 1", bus.o_empty); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if (bus.o_wen_ctrl !== 1'b1 || bus.o_waddr !== ADDR_W'(exp_addr[n])) begin errors++; $display("FAIL wrap_addr n=%0d got wen=%b addr=%0d exp 1 %0d", n, bus.o_wen_ctrl, bus.o_waddr, exp_addr[n]); end
      n++;
    end
    checks++; if (bus.o_count !== CW'(3)) begin errors++; $display("FAIL wrap_count got %0d exp 3", bus.o_count); end
  endtask

  task automatic test_full_rw();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_full !== 1'b1) begin errors++; $display("FAIL fullrw_full got %b exp 1", bus.o_full); end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.o_wen_ctrl !== 1'b0) begin errors++; $display("FAIL fullrw_wen got %b exp 0", bus.o_wen_ctrl); end
    checks++; if (bus.o_count !== CW'(DEPTH - 1)) begin errors++; $display("FAIL fullrw_count got %0d exp %0d", bus.o_count, DEPTH - 1); end
    checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL fullrw_full2 got %b exp 0", bus.o_full); end
  endtask

  task automatic test_empty_rw();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.o_count !== CW'(1)) begin errors++; $display("FAIL emptyrw_count got %0d exp 1", bus.o_count); end
    checks++; if (bus.o_empty !== 1'b0) begin errors++; $display("FAIL emptyrw_empty got %b exp 0", bus.o_empty); end
    checks++; if (bus.o_udf !== ERR_EN) begin errors++; $display("FAIL emptyrw_udf got %b exp %b", bus.o_udf, ERR_EN); end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.o_udf !== 1'b0) begin errors++; $display("FAIL emptyrw_clr got %b exp 0", bus.o_udf); end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.o_udf !== ERR_EN) begin errors++; $display("FAIL emptyrw_setwins got %b exp %b", bus.o_udf, ERR_EN); end
    checks++; if (bus.o_count !== '0) begin errors++; $display("FAIL emptyrw_floor got %0d exp 0", bus.o_count); end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.o_udf !== 1'b0) begin errors++; $display("FAIL emptyrw_clr2 got %b exp 0", bus.o_udf); end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_count !== CW'(3)) begin errors++; $display("FAIL rstmid_pre got %0d exp 3", bus.o_count); end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_count !== '0 || bus.o_empty !== 1'b1) begin errors++; $display("FAIL rstmid_state got count=%0d empty=%b exp 0 1", bus.o_count, bus.o_empty); end
    checks++; if (bus.o_wen_ctrl !== 1'b0) begin errors++; $display("FAIL rstmid_wen got %b exp 0", bus.o_wen_ctrl); end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_wen_ctrl !== 1'b1 || bus.o_waddr !== '0) begin errors++; $display("FAIL rstmid_next got wen=%b addr=%0d exp 1 0", bus.o_wen_ctrl, bus.o_waddr); end
  endtask

  task automatic test_random();
    bit rst_n, wen, ren, clr;
    int wbias;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      wbias = ((i / 60) % 2 == 0) ? 80 : 25;
      rst_n = ($urandom_range(0, 79) != 0);
      wen   = ($urandom_range(0, 99) < wbias);
      ren   = ($urandom_range(0, 99) < 105 - wbias);
      clr   = ($urandom_range(0, 19) == 0);
      step(rst_n, wen, ren, clr);
      checks++; if (bus.o_count !== CW'(m_cnt)) begin errors++; $display("FAIL rnd_count i=%0d got %0d exp %0d", i, bus.o_count, m_cnt); end
      checks++; if (bus.o_wen_ctrl !== m_wen) begin errors++; $display("FAIL rnd_wen i=%0d got %b exp %b", i, bus.o_wen_ctrl, m_wen); end
      checks++; if (bus.o_waddr !== ADDR_W'(m_waddr)) begin errors++; $display("FAIL rnd_waddr i=%0d got %0d exp %0d", i, bus.o_waddr, m_waddr); end
      checks++; if (bus.o_full !== (m_cnt == DEPTH)) begin errors++; $display("FAIL rnd_full i=%0d got %b exp %b", i, bus.o_full, m_cnt == DEPTH); end
      checks++; if (bus.o_almost_full !== (m_cnt >= DEPTH - AF_MARGIN)) begin errors++; $display("FAIL rnd_af i=%0d got %b exp %b", i, bus.o_almost_full, m_cnt >= DEPTH - AF_MARGIN); end
      checks++; if (bus.o_empty !== (m_cnt == 0)) begin errors++; $display("FAIL rnd_empty i=%0d got %b exp %b", i, bus.o_empty, m_cnt == 0); end
      checks++; if (bus.o_ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf i=%0d got %b exp %b", i, bus.o_ovf, m_ovf); end
      checks++; if (bus.o_udf !== m_udf) begin errors++; $display("FAIL rnd_udf i=%0d got %b exp %b", i, bus.o_udf, m_udf); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_full_rw();
    test_empty_rw();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_ctrl.md
Name: fifo_write_ctrl

Overview:
- Write-side controller for the block FIFO; the counterpart of the read-side enable controller.
- Gates the upstream write request against FIFO occupancy and generates a registered write strobe plus write address for the RAM.
- Maintains the occupancy count from the accepted-write and accepted-read pulses.
- Exports o_full / o_almost_full to the writer and o_empty to the read-side controller.

Parameters:
- DEPTH, 16, number of FIFO entries; any value >= 2, power of two not required.
- ADDR_W, 4, RAM address width; must satisfy 2^ADDR_W >= DEPTH.
- AF_MARGIN, 2, o_almost_full asserts when count >= DEPTH - AF_MARGIN; range 1..DEPTH-1.

Ports:
- i_clk  input  1  single clock; all state on rising edge.
- i_rest  input  1  synchronous active-low reset; acts only on a rising i_clk edge while 0.
- i_wen  input  1  write request from upstream; level, one entry per cycle.
- i_ren_ctrl  input  1  accepted-read pulse from the read-side controller; one entry consumed per cycle.
- i_err_clr  input  1  clears sticky error flags (only with FIFO_WR_ERR_EN).
- o_wen_ctrl  output  1  registered RAM write strobe.
- o_waddr  output  ADDR_W  registered RAM write address, valid with o_wen_ctrl.
- o_full  output  1  count == DEPTH.
- o_almost_full  output  1  count >= DEPTH - AF_MARGIN.
- o_empty  output  1  count == 0; drives the read side's i_empty.
- o_count  output  ADDR_W+1  current occupancy.
- o_ovf  output  1  sticky overflow flag.
- o_udf  output  1  sticky underflow flag.

Behaviour:
- Reset (i_rest == 0 at an edge):
  - wptr = 0, count = 0.
  - o_wen_ctrl = 0, o_waddr = 0.
  - o_full = 0, o_almost_full = 0, o_empty = 1, o_count = 0.
  - o_ovf = 0, o_udf = 0.
- Reset asserted mid-operation discards all content; no write strobe is issued in the reset cycle.
- accept = i_wen & ~o_full, evaluated on the registered count.
- At each edge:
  - o_wen_ctrl <= accept.
  - o_waddr <= wptr.
  - If accept: wptr <= (wptr == DEPTH-1) ? 0 : wptr + 1. Wrap is explicit, not modulo 2^ADDR_W.
- Latency: request at edge N produces o_wen_ctrl/o_waddr valid during cycle N+1, one-cycle registered, same as the read side.
- rd_ok = i_ren_ctrl & ~o_empty. A read while empty is ignored.
- Count update: count <= count + accept - rd_ok.
  - Simultaneous accept and rd_ok leaves count unchanged.
- Full with simultaneous read and write: the write is rejected (conservative, registered full); count decrements by 1.
- Empty with simultaneous write and read: the read is ignored; count becomes 1.
- Flags o_full, o_almost_full, o_empty are decoded from registered count, so they are valid in the same cycle as o_count.
- count never exceeds DEPTH and never goes below 0.
- The module contains no combinational path from inputs to outputs.

Optional Feature:
- Macro FIFO_WR_ERR_EN.
- Defined:
  - o_ovf sets on i_wen & o_full; o_udf sets on i_ren_ctrl & o_empty.
  - Both are sticky until i_err_clr == 1 at an edge.
  - If set and clear occur in the same cycle, set wins.
- Undefined:
  - o_ovf and o_udf are tied to 0.
  - i_err_clr is ignored.
  - No flag registers are inferred.

Test Plan:
- DEPTH=4: reset, then i_wen=1 for 6 cycles -> o_wen_ctrl high 4 cycles with o_waddr 0,1,2,3; o_full=1 after the 4th accept; o_almost_full=1 from count 2; o_ovf=1 with the macro defined.
- DEPTH=5: 5 writes, 5 reads, 3 writes -> o_waddr sequence 0..4,0,1,2 (wrap at 4, not 7); o_count=3.
- Full (count=4), i_wen=1 and i_ren_ctrl=1 in the same cycle -> o_wen_ctrl=0 next cycle, o_count=3.
- Empty, i_wen=1 and i_ren_ctrl=1 in the same cycle -> o_count=1, o_empty=0; o_udf=1 with the macro, then i_err_clr=1 -> o_udf=0.
- count=3, wptr=3, i_rest=0 for one edge with i_wen=1 -> o_count=0, o_empty=1, o_wen_ctrl=0; next write uses o_waddr=0.
